// File: rtl/cmp2_result_checker.sv
// Checks a 2-bit magnitude comparator: per-vector expected-vs-observed, tallies, coverage, verdict.
// Latency: stats visible the cycle after the accepting edge; done pulses the cycle after the NVEC-th accept.
// Backpressure: none; every in_valid cycle in RUN is accepted, gaps in in_valid are free.
module cmp2_result_checker #(
    parameter int NVEC  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             A1,
    input  logic             A0,
    input  logic             B1,
    input  logic             B0,
    input  logic             AgtB,
    input  logic             AeqB,
    input  logic             AltB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [15:0]      cov_map,
    output logic             first_err_valid,
    output logic [3:0]       first_err_idx,
    output logic             onehot_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]       LAST_IDX = 8'(NVEC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    // Coverage only means something when the run is long enough to hit all 16 vectors.
    localparam bit               COV_REQ  = (NVEC >= 16);

    state_t      state, state_nx;
    logic [7:0]  vec_cnt;

    logic        accept;
    logic        last_vec;
    logic [1:0]  opa, opb;
    logic [3:0]  idx;
    logic [2:0]  exp_pat, got_pat;
    logic        onehot_ok;
    logic        mismatch;
    logic [CNT_W-1:0] err_nx;
    logic [15:0] cov_nx;
    logic        pass_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    // Per-vector evaluation; a non-one-hot observation can never equal the one-hot expectation,
    // so it is automatically counted as a mismatch.
    always_comb begin
        opa       = {A1, A0};
        opb       = {B1, B0};
        idx       = {A1, A0, B1, B0};
        exp_pat   = {opa > opb, opa == opb, opa < opb};
        got_pat   = {AgtB, AeqB, AltB};
        onehot_ok = (got_pat == 3'b100) || (got_pat == 3'b010) || (got_pat == 3'b001);
        mismatch  = (got_pat != exp_pat);
        accept    = (state == RUN) && in_valid;
        last_vec  = accept && (vec_cnt == LAST_IDX);
        err_nx    = (accept && mismatch) ? sat_inc(err_count) : err_count;
        cov_nx    = accept ? (cov_map | (16'b1 << idx)) : cov_map;
        pass_nx   = (err_nx == '0) && (!COV_REQ || (cov_nx == 16'hFFFF));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; start only matters in IDLE, DONE lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_vec) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and run statistics; cleared on an accepted start, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            gt_count        <= '0;
            eq_count        <= '0;
            lt_count        <= '0;
            cov_map         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            onehot_err      <= 1'b0;
            vec_cnt         <= '0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            if (state == IDLE && start) begin
                pass            <= 1'b0;
                err_count       <= '0;
                gt_count        <= '0;
                eq_count        <= '0;
                lt_count        <= '0;
                cov_map         <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                onehot_err      <= 1'b0;
                vec_cnt         <= '0;
            end else if (accept) begin
                vec_cnt   <= vec_cnt + 8'd1;
                err_count <= err_nx;
                cov_map   <= cov_nx;
                if (mismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= idx;
                end
                if (!onehot_ok) begin
                    onehot_err <= 1'b1;
                end else if (AgtB) begin
                    gt_count <= sat_inc(gt_count);
                end else if (AeqB) begin
                    eq_count <= sat_inc(eq_count);
                end else begin
                    lt_count <= sat_inc(lt_count);
                end
                if (last_vec) pass <= pass_nx;
            end
        end
    end

endmodule

// File: tb/tb_cmp2_result_checker.sv
module tb_cmp2_result_checker;

    localparam int CW = 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic A1 = 1'b0, A0 = 1'b0, B1 = 1'b0, B0 = 1'b0;
    logic AgtB = 1'b0, AeqB = 1'b0, AltB = 1'b0;
    logic busy, done, pass, first_err_valid, onehot_err;
    logic [CW-1:0] err_count, gt_count, eq_count, lt_count;
    logic [15:0] cov_map;
    logic [3:0]  first_err_idx;

    cmp2_result_checker #(.NVEC(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .A1(A1), .A0(A0), .B1(B1), .B0(B0),
        .AgtB(AgtB), .AeqB(AeqB), .AltB(AltB),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
        .cov_map(cov_map), .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         id;
        int         fault_idx;   // 16 = no fault injected
        logic [2:0] fault_pat;   // {AgtB,AeqB,AltB} driven at fault_idx
        bit         hole;        // idx0 twice, idx15 omitted
        bit         gaps;        // alternate in_valid, start mid-run, in_valid in IDLE
        int         e_err, e_gt, e_eq, e_lt;
        logic [15:0] e_cov;
        bit         e_pass, e_fev;
        int         e_fei;
        bit         e_oh;
        int         e_busy;
    } scn_t;

    scn_t sc [5];
    scn_t exp_q[$];
    int   done_cyc_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector with a correct comparator response, unless it is the faulted index.
    task automatic set_vec(input int idx, input int fidx, input logic [2:0] fpat);
        int a, b;
        logic [3:0] v;
        logic [2:0] r;
        v = idx[3:0];
        a = idx / 4;
        b = idx % 4;
        r = {a > b, a == b, a < b};
        if (idx == fidx) r = fpat;
        {A1, A0, B1, B0} = v;
        {AgtB, AeqB, AltB} = r;
    endtask

    task automatic run_scn(input scn_t s);
        int idx;
        exp_q.push_back(s);
        if (s.gaps) begin
            set_vec(3, 16, 3'b000);
            in_valid = 1'b1;
            tick();
        end
        start    = 1'b1;
        in_valid = s.gaps;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (s.gaps) begin
                in_valid = 1'b0;
                start    = (k == 8);
                tick();
                start = 1'b0;
            end
            idx = s.hole ? ((k == 0) ? 0 : k - 1) : k;
            set_vec(idx, s.fault_idx, s.fault_pat);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        done_cyc_q.push_back(cyc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
            done_cyc_q.delete();
        end
    endtask

    // Scoreboard side: each done pulse pops one expected result record.
    scn_t mon_e;
    int   mon_dc;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_dc = (done_cyc_q.size() != 0) ? done_cyc_q.pop_front() : -1;
                    chk($sformatf("s%0d_done_cycle", mon_e.id), cyc, mon_dc);
                    chk($sformatf("s%0d_busy_cycles", mon_e.id), busy_cnt, mon_e.e_busy);
                    chk($sformatf("s%0d_busy_at_done", mon_e.id), busy, 0);
                    chk($sformatf("s%0d_err", mon_e.id), err_count, mon_e.e_err);
                    chk($sformatf("s%0d_gt", mon_e.id), gt_count, mon_e.e_gt);
                    chk($sformatf("s%0d_eq", mon_e.id), eq_count, mon_e.e_eq);
                    chk($sformatf("s%0d_lt", mon_e.id), lt_count, mon_e.e_lt);
                    chk($sformatf("s%0d_cov", mon_e.id), cov_map, mon_e.e_cov);
                    chk($sformatf("s%0d_pass", mon_e.id), pass, mon_e.e_pass);
                    chk($sformatf("s%0d_first_err_valid", mon_e.id), first_err_valid, mon_e.e_fev);
                    if (mon_e.e_fev)
                        chk($sformatf("s%0d_first_err_idx", mon_e.id), first_err_idx, mon_e.e_fei);
                    chk($sformatf("s%0d_onehot_err", mon_e.id), onehot_err, mon_e.e_oh);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        //        id fidx pat     hole gaps err gt eq lt cov       pass fev fei oh busy
        sc[0] = '{0, 16, 3'b000, 0,   0,   0,  6, 4, 6, 16'hFFFF, 1,   0,  0,  0, 16};
        sc[1] = '{1,  9, 3'b001, 0,   0,   1,  5, 4, 7, 16'hFFFF, 0,   1,  9,  0, 16};
        sc[2] = '{2,  5, 3'b110, 0,   0,   1,  6, 3, 6, 16'hFFFF, 0,   1,  5,  1, 16};
        sc[3] = '{3, 16, 3'b000, 1,   0,   0,  6, 4, 6, 16'h7FFF, 0,   0,  0,  0, 16};
        sc[4] = '{4, 16, 3'b000, 0,   1,   0,  6, 4, 6, 16'hFFFF, 1,   0,  0,  0, 32};

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_cov", cov_map, 0);
        chk("rst_first_err_valid", first_err_valid, 0);
        chk("rst_onehot_err", onehot_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_scn(sc[i]);
            wait_drain();
            if (i == 0) begin
                repeat (3) tick();
                chk("hold_pass", pass, 1);
                chk("hold_busy", busy, 0);
                chk("hold_done", done, 0);
                chk("hold_cov", cov_map, 16'hFFFF);
            end
        end

        // Abort after 7 accepted vectors: asynchronous reset, no done expected.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_vec(k, 16, 3'b000);
            in_valid = 1'b1;
            tick();
        end
        chk("pre_abort_lt", lt_count, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_gt", gt_count, 0);
        chk("abort_eq", eq_count, 0);
        chk("abort_lt", lt_count, 0);
        chk("abort_cov", cov_map, 0);
        chk("abort_done", done, 0);
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        run_scn(sc[0]);
        wait_drain();

        chk("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp2_result_checker.md
Name: cmp2_result_checker

Overview:
Downstream checking stage for the 2-bit gate-level magnitude comparator. It samples the comparator operands (A1,A0,B1,B0) and its outputs (AgtB,AeqB,AltB) under a valid strobe and computes the expected relation. It counts mismatches, tallies gt/eq/lt outcomes and tracks coverage of the 16 operand combinations over one run. It gives an in-silicon pass/fail for the comparator that the directed sweep currently checks only by eye.

Parameters:
NVEC, 16, number of accepted vectors that completes one run (1..255)
CNT_W, 8, width of all counters; counters saturate at 2^CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin run; honoured only in IDLE
in_valid  input  1  operand/result sample valid this cycle
A1  input  1  operand A msb
A0  input  1  operand A lsb
B1  input  1  operand B msb
B0  input  1  operand B lsb
AgtB  input  1  comparator output A>B
AeqB  input  1  comparator output A==B
AltB  input  1  comparator output A<B
busy  output  1  high in RUN
done  output  1  one-cycle pulse at end of run
pass  output  1  result of last run, held until next start
err_count  output  CNT_W  mismatching vectors
gt_count  output  CNT_W  accepted vectors with AgtB only
eq_count  output  CNT_W  accepted vectors with AeqB only
lt_count  output  CNT_W  accepted vectors with AltB only
cov_map  output  16  bit idx={A1,A0,B1,B0} set when that vector was seen
first_err_valid  output  1  a mismatch has been recorded this run
first_err_idx  output  4  idx of first mismatching vector
onehot_err  output  1  sticky: some vector had not exactly one output high

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low. On reset every output is 0, FSM goes to IDLE, internal vector counter is 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → clear all counters, cov_map, first_err_*, onehot_err and pass; go to RUN. in_valid in IDLE is ignored, including in the same cycle as start.
- RUN: busy=1. Each cycle with in_valid=1 accepts one vector:
  - expected gt/eq/lt is computed from A={A1,A0} and B={B1,B0}, unsigned.
  - Mismatch if {AgtB,AeqB,AltB} differs from the expected one-hot pattern. On mismatch, err_count increments.
  - On the first mismatch of the run, capture first_err_idx and set first_err_valid.
  - If the output is not exactly one-hot: set onehot_err (sticky), count the vector as a mismatch, and do not tally it into gt/eq/lt.
  - If the output is one-hot (correct or wrong), tally the asserted output into its counter.
  - cov_map[idx] is set. The vector counter increments.
  - Gaps in in_valid are allowed and add no penalty. start is ignored in RUN.
- The edge that accepts the NVEC-th vector moves the FSM to DONE. All stats are visible the cycle after the accepting edge.
- DONE (one cycle): done=1, busy=0. pass=1 iff err_count==0 and, when NVEC>=16, cov_map==16'hFFFF. For NVEC<16 the coverage term is waived. Next state is IDLE. in_valid and start are ignored in DONE.
- Outputs other than done and busy hold their values in IDLE until the next accepted start.
- Counters saturate and never wrap.
- Reset mid-run aborts immediately and returns every output to its reset value. No done pulse is produced.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Sweep: start at cycle 0, then the 16 vectors in idx order 0..15 on cycles 1..16 with a correct comparator model → done pulse at cycle 17 only, err=0, gt=6, eq=4, lt=6, cov_map=16'hFFFF, pass=1, busy high on cycles 1..16.
- Fault injection at idx 9 (A=2,B=1), driving AltB=1 and AgtB=0 → err=1, first_err_valid=1, first_err_idx=9, gt=5, lt=7, pass=0.
- One-hot violation at idx 5 (A=B=1), driving AgtB=1 and AeqB=1 → err=1, onehot_err=1, eq=3, gt=6, pass=0.
- Coverage hole: 16 vectors with idx 0 sent twice and idx 15 omitted → err=0, cov_map=16'h7FFF, pass=0.
- Protocol: in_valid deasserted on alternate cycles, start pulsed mid-RUN, in_valid asserted in IDLE before start → only the 16 RUN-accepted vectors counted, done at the cycle after the 16th accept, sweep results as in the first scenario.
- Reset: rst_n dropped asynchronously after 7 vectors → all outputs 0 immediately, no done. A fresh start plus the sweep then gives the pass=1 results of the first scenario.
